// File: rtl/seg_scan_display.sv
// seg_scan_display: 8-digit multiplexed seven-segment controller for the
// ticket machine. A load pulse captures money, change, ticket type and count;
// both money values are converted to BCD by a sequential double-dabble, then
// the eight digit registers are refreshed in a single cycle so the display
// never shows a half-converted value. The digits are scanned onto an/sseg
// with leading-zero blanking, per-digit blink and per-digit decimal points.
module seg_scan_display #(
  parameter int VAL_W     = 8,
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 250,
  parameter int BLANK_LZ  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VAL_W-1:0] money,
  input  logic [VAL_W-1:0] moneyReturn,
  input  logic [2:0]       ticketType,
  input  logic [2:0]       ticketCount,
  input  logic             load,
  input  logic [7:0]       blink_en,
  input  logic [7:0]       dp_in,
  output logic             busy,
  output logic [7:0]       an,
  output logic [7:0]       sseg
);

  localparam int CW = $clog2(VAL_W + 1);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(VAL_W - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic          LZ_ON      = (BLANK_LZ != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_DONE
  } state_t;

  // Active-low segment pattern {g,f,e,d,c,b,a}; anything outside 0-9 is dark.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'd0:    p = 7'h40;
      4'd1:    p = 7'h79;
      4'd2:    p = 7'h24;
      4'd3:    p = 7'h30;
      4'd4:    p = 7'h19;
      4'd5:    p = 7'h12;
      4'd6:    p = 7'h02;
      4'd7:    p = 7'h78;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h10;
      default: p = 7'h7F;
    endcase
    return p;
  endfunction

  state_t           state_reg, state_next;
  logic             cap_en, shift_en, wr_en;
  logic [CW-1:0]    cnt_reg;

  // Channel 0 converts money, channel 1 converts moneyReturn.
  logic [VAL_W-1:0] bin_reg  [2];
  logic [11:0]      bcd_reg  [2];
  logic [11:0]      bcd_step [2];
  logic [2:0]       type_sh_reg, count_sh_reg;

  logic [3:0]       digit_reg [8];
  logic [7:0]       blank_vec;
  logic [6:0]       seg_pat [8];

  logic [PW-1:0]    presc_reg;
  logic             scan_tick;
  logic             active_reg;
  logic [2:0]       idx_reg;
  logic [BW-1:0]    blink_cnt_reg;
  logic             blink_phase_reg;
  logic [7:0]       an_reg, sseg_reg;

  // Conversion FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // Next state and datapath strobes; busy covers CONV and the DONE write cycle.
  always_comb begin
    state_next = state_reg;
    cap_en     = 1'b0;
    shift_en   = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (load) begin
          cap_en     = 1'b1;
          state_next = ST_CONV;
        end
      end
      ST_CONV: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        if (cnt_reg == CNT_LAST) state_next = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        wr_en      = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // One double-dabble step per channel: add 3 to units/tens nibbles >= 5,
  // then shift in the next binary bit. The hundreds nibble never exceeds 2
  // before the final shift (value <= 511), so it needs no correction.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_dd
      logic [7:0] adj;
      for (genvar gj = 0; gj < 2; gj++) begin : gen_nib
        assign adj[4*gj +: 4] = (bcd_reg[gi][4*gj +: 4] >= 4'd5) ?
                                (bcd_reg[gi][4*gj +: 4] + 4'd3) :
                                bcd_reg[gi][4*gj +: 4];
      end
      assign bcd_step[gi] = {bcd_reg[gi][10:8], adj, bin_reg[gi][VAL_W-1]};
    end
  endgenerate

  // Shadow capture on load, then VAL_W shift steps with a step counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < 2; c++) begin
        bin_reg[c] <= '0;
        bcd_reg[c] <= '0;
      end
      type_sh_reg  <= '0;
      count_sh_reg <= '0;
      cnt_reg      <= '0;
    end else if (cap_en) begin
      bin_reg[0]   <= money;
      bin_reg[1]   <= moneyReturn;
      bcd_reg[0]   <= '0;
      bcd_reg[1]   <= '0;
      type_sh_reg  <= ticketType;
      count_sh_reg <= ticketCount;
      cnt_reg      <= '0;
    end else if (shift_en) begin
      for (int c = 0; c < 2; c++) begin
        bin_reg[c] <= bin_reg[c] << 1;
        bcd_reg[c] <= bcd_step[c];
      end
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Digit registers change only in the DONE cycle, all eight at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 8; d++) digit_reg[d] <= '0;
    end else if (wr_en) begin
      digit_reg[7] <= {1'b0, type_sh_reg};
      digit_reg[6] <= {1'b0, count_sh_reg};
      digit_reg[5] <= bcd_reg[0][11:8];
      digit_reg[4] <= bcd_reg[0][7:4];
      digit_reg[3] <= bcd_reg[0][3:0];
      digit_reg[2] <= bcd_reg[1][11:8];
      digit_reg[1] <= bcd_reg[1][7:4];
      digit_reg[0] <= bcd_reg[1][3:0];
    end
  end

  // Per-digit segment pattern with leading-zero blanking of the money fields.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : gen_dec
      if (gi == 5 || gi == 2) begin : gen_hund
        assign blank_vec[gi] = LZ_ON && (digit_reg[gi] == 4'd0);
      end else if (gi == 4 || gi == 1) begin : gen_tens
        assign blank_vec[gi] = LZ_ON && (digit_reg[gi+1] == 4'd0) &&
                               (digit_reg[gi] == 4'd0);
      end else begin : gen_none
        assign blank_vec[gi] = 1'b0;
      end
      assign seg_pat[gi] = blank_vec[gi] ? 7'h7F : seg7(digit_reg[gi]);
    end
  endgenerate

  assign scan_tick = (presc_reg == PRESC_LAST);

  // Scan prescaler, digit index and blink phase. The first tick only enables
  // the outputs so the walk starts on digit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_reg       <= '0;
      active_reg      <= 1'b0;
      idx_reg         <= '0;
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else begin
      presc_reg <= scan_tick ? '0 : presc_reg + 1'b1;
      if (scan_tick) begin
        active_reg <= 1'b1;
        if (active_reg) idx_reg <= idx_reg + 3'd1;
        if (blink_cnt_reg == BLINK_LAST) begin
          blink_cnt_reg   <= '0;
          blink_phase_reg <= ~blink_phase_reg;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
      end
    end
  end

  // Registered pin drive: one anode low, segments of that digit or dark when blinked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_reg   <= 8'hFF;
      sseg_reg <= 8'hFF;
    end else if (!active_reg) begin
      an_reg   <= 8'hFF;
      sseg_reg <= 8'hFF;
    end else begin
      an_reg <= ~(8'd1 << idx_reg);
      if (blink_phase_reg && blink_en[idx_reg]) sseg_reg <= 8'hFF;
      else                                      sseg_reg <= {dp_in[idx_reg], seg_pat[idx_reg]};
    end
  end

  assign an   = an_reg;
  assign sseg = sseg_reg;

endmodule
